// File: rtl/div_pkg.sv
// div_pkg: shared widths, handshake levels and FSM state encodings for the divider.
package div_pkg;
    localparam int REG_BUS = 32;
    localparam int DOUBLE_REG_BUS = 64;
    localparam logic DIV_RESULT_READY = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP = 1'b0;
    typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring subtract-and-shift step on the working register (bit 64 not needed).
module div_step import div_pkg::*; (
    input  logic [DOUBLE_REG_BUS-1:0] work,
    input  logic [REG_BUS-1:0]        divisor,
    output logic [DOUBLE_REG_BUS:0]   next
);
    logic [REG_BUS:0] diff;
    assign diff = {1'b0, work[63:32]} - {1'b0, divisor};
    assign next = diff[REG_BUS] ? {work, 1'b0} : {diff[31:0], work[31:0], 1'b1};
endmodule

// File: rtl/div.sv
// div: 32-cycle restoring divider, result {remainder, quotient}.
// Signed operation and sign fixup exist only when DIV_SIGNED_EN is defined.
module div import div_pkg::*; (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);
    div_state_e state;
    logic [5:0] cnt;
    logic [DOUBLE_REG_BUS:0] work, work_next;
    logic [REG_BUS-1:0] divisor, mag_a, mag_b, quo, rem;
    logic accept;
    assign accept = start_i == DIV_START && !annul_i;
`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;
    assign mag_a = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign mag_b = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    assign quo = neg_q ? -work[31:0] : work[31:0];
    assign rem = neg_r ? -work[64:33] : work[64:33];
    always_ff @(posedge clk or posedge rst)
        if (rst)
            {neg_q, neg_r} <= 2'b00;
        else if (state == DIV_FREE && accept)
            {neg_q, neg_r} <= {signed_div_i & (opdata1_i[31] ^ opdata2_i[31]), signed_div_i & opdata1_i[31]};
`else
    logic unused_signed;
    assign unused_signed = signed_div_i;
    assign mag_a = opdata1_i;
    assign mag_b = opdata2_i;
    assign quo = work[31:0];
    assign rem = work[64:33];
`endif
    div_step u_step (.work(work[63:0]), .divisor(divisor), .next(work_next));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_FREE;
            cnt <= 6'd0;
            work <= '0;
            divisor <= '0;
            ready_o <= DIV_RESULT_NOT_READY;
            result_o <= '0;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                    if (accept && opdata2_i == '0)
                        state <= DIV_BY_ZERO;
                    else if (accept) begin
                        state <= DIV_ON;
                        cnt <= 6'd0;
                        work <= {32'b0, mag_a, 1'b0};
                        divisor <= mag_b;
                    end
                end
                DIV_BY_ZERO: begin
                    work <= '0;
                    result_o <= '0;
                    state <= DIV_END;
                end
                DIV_ON: begin
                    if (annul_i)
                        state <= DIV_FREE;
                    else if (cnt != 6'd32) begin
                        work <= work_next;
                        cnt <= cnt + 6'd1;
                    end else begin
                        state <= DIV_END;
                        result_o <= {rem, quo};
                        ready_o <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    // zero-divisor path arrives here not yet ready and raises ready one edge later
                    if (start_i == DIV_START)
                        ready_o <= DIV_RESULT_READY;
                    else begin
                        state <= DIV_FREE;
                        ready_o <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed checks of div against a latency/arithmetic reference model.
module tb_div;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    logic clk = 0, rst = 1, signed_div_i = 0, start_i = 0, annul_i = 0;
    logic [31:0] opdata1_i = 0, opdata2_i = 0;
    logic [63:0] result_o;
    logic ready_o;
    int checks = 0, failures = 0;

    div dut (.clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
             .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
             .result_o(result_o), .ready_o(ready_o));

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
        logic [31:0] ma, mb, q, r;
        logic sg;
        sg = s & SIGNED_EN;
        if (b == 0) return 64'h0;
        ma = (sg && a[31]) ? 32'(0 - a) : a;
        mb = (sg && b[31]) ? 32'(0 - b) : b;
        q = ma / mb;
        r = ma % mb;
        if (sg && (a[31] ^ b[31])) q = 32'(0 - q);
        if (sg && a[31]) r = 32'(0 - r);
        return {r, q};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: an accepted request becomes ready a fixed number of edges later
    logic m_busy = 0, m_zero = 0, m_ready = 0;
    int m_left = 0;
    logic [63:0] m_res = 0, m_out = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0;
            m_ready <= 0;
            m_out <= 0;
        end else if (m_ready) begin
            if (!start_i) begin
                m_ready <= 0;
                m_out <= 0;
            end
        end else if (m_busy) begin
            if (!m_zero && annul_i)
                m_busy <= 0;
            else if (m_left == 1) begin
                m_busy <= 0;
                m_ready <= 1;
                m_out <= m_res;
            end else
                m_left <= m_left - 1;
        end else if (start_i && !annul_i) begin
            m_busy <= 1;
            m_zero <= opdata2_i == 0;
            m_left <= opdata2_i == 0 ? 2 : 33;
            m_res <= ref_div(opdata1_i, opdata2_i, signed_div_i);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_cycle", {63'b0, ready_o}, {63'b0, m_ready});
            if (m_ready) chk("result_cycle", result_o, m_out);
        end
    end

    task automatic do_op(logic [31:0] a, logic [31:0] b, logic s, output int lat, output logic [63:0] res);
        int n;
        @(negedge clk);
        opdata1_i = a;
        opdata2_i = b;
        signed_div_i = s;
        start_i = 1;
        n = 0;
        lat = -1;
        res = 'x;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (ready_o) begin
                lat = n - 1;
                res = result_o;
                break;
            end
        end
        if (lat < 0) begin
            failures++;
            checks++;
            $display("FAIL timeout: no ready_o for %h / %h", a, b);
        end
        @(negedge clk);
        start_i = 0;
        @(posedge clk);
        #1;
        chk("ready_drop", {63'b0, ready_o}, 64'h0);
        chk("result_drop", result_o, 64'h0);
    endtask

    initial begin
        int lat;
        logic [63:0] res;
        logic [31:0] a, b;
        logic s;
        chk("model_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        chk("model_div0", ref_div(32'd5, 32'd0, 1'b0), 64'h0);
        chk("model_max_1", ref_div(32'hFFFFFFFF, 32'd1, 1'b0), {32'h0, 32'hFFFFFFFF});
        repeat (2) @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("reset_ready", {63'b0, ready_o}, 64'h0);
        chk("reset_result", result_o, 64'h0);

        do_op(32'd100, 32'd7, 1'b0, lat, res);
        chk("u100_7_lat", 64'(lat), 64'd33);
        chk("u100_7_res", res, {32'd2, 32'd14});
        do_op(32'd5, 32'd0, 1'b0, lat, res);
        chk("div0_lat", 64'(lat), 64'd2);
        chk("div0_res", res, 64'h0);
        do_op(32'hFFFFFFFF, 32'd1, 1'b0, lat, res);
        chk("max_1_res", res, {32'h0, 32'hFFFFFFFF});
        do_op(32'hFFFFFFF9, 32'd2, 1'b1, lat, res);
        chk("neg7_2_res", res, SIGNED_EN ? {32'hFFFFFFFF, 32'hFFFFFFFD} : {32'd1, 32'h7FFFFFFC});
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, res);
        chk("minint_m1_res", res, SIGNED_EN ? {32'h0, 32'h80000000} : {32'h80000000, 32'h0});

        // annul at E0+10 of a fresh 100 / 7
        @(negedge clk);
        opdata1_i = 100;
        opdata2_i = 7;
        signed_div_i = 0;
        start_i = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1;
        start_i = 0;
        @(negedge clk);
        annul_i = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("annul_no_ready", {63'b0, ready_o}, 64'h0);
        end
        do_op(32'd9, 32'd3, 1'b0, lat, res);
        chk("u9_3_res", res, {32'd0, 32'd3});

        // reset mid-division, then reset while a result is being held
        @(negedge clk);
        opdata1_i = 100;
        opdata2_i = 7;
        start_i = 1;
        repeat (6) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("rst_mid_ready", {63'b0, ready_o}, 64'h0);
        chk("rst_mid_result", result_o, 64'h0);
        start_i = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        opdata1_i = 100;
        start_i = 1;
        repeat (40) @(posedge clk);
        #3;
        chk("hold_ready", {63'b0, ready_o}, 64'h1);
        chk("hold_result", result_o, {32'd2, 32'd14});
        rst = 1;
        #1;
        chk("rst_end_ready", {63'b0, ready_o}, 64'h0);
        chk("rst_end_result", result_o, 64'h0);
        start_i = 0;
        @(negedge clk);
        rst = 0;
        do_op(32'd100, 32'd7, 1'b0, lat, res);
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst_res", res, {32'd2, 32'd14});

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 0;
                1: b = $urandom_range(1, 15);
                2: b = {$urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0, 16'($urandom)};
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            do_op(a, b, s, lat, res);
            chk("rand_res", res, ref_div(a, b, s));
            chk("rand_lat", 64'(lat), b == 0 ? 64'd2 : 64'd33);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
